fifo_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one buffer write port (wr_en/wr_data, full flag) among NUM_REQ producers. Each producer presents a word with a level request and receives a one-cycle ack when its word has been written. The block sequences the buffer port so that it never writes while the buffer reports full and never issues a write before the full flag reflects the previous write. It sits between bus/microcode producers and the shared 32-bit mailbox buffer.

---
 rtl/fifo_write_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one buffer write port among NUM_REQ producers (IDLE -> WRITE -> SETTLE).
// Optional macro FIFO_ARB_LOCK_EN adds a per-requester lock input that keeps a burst on one requester.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef FIFO_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock,
`endif
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WRITE, SETTLE} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          last_q, last_d;
  logic                   wr_en_q, wr_en_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic                   busy_q, busy_d;

  logic                   found;
  logic [GW-1:0]          win;
  logic [GW-1:0]          cand;
  logic                   sel_vld;
  logic [GW-1:0]          sel;
  logic                   hold_c;

  // First requester found scanning upward from the one after last_q.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

`ifdef FIFO_ARB_LOCK_EN
  logic lock_q, lock_d;
  assign hold_c = lock_q && lock[last_q] && req[last_q];
`else
  assign hold_c = 1'b0;
`endif

  assign sel_vld = hold_c | found;
  assign sel     = hold_c ? last_q : win;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wr_en_d = 1'b0;
    ack_d   = '0;
    data_d  = data_q;
    grant_d = grant_q;
`ifdef FIFO_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef FIFO_ARB_LOCK_EN
        // A lock survives only while its owner keeps both lock and req high.
        lock_d = hold_c;
`endif
        if (sel_vld && !fifo_full) begin
          state_d    = WRITE;
          wr_en_d    = 1'b1;
          ack_d[sel] = 1'b1;
          data_d     = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
          grant_d    = sel;
          last_d     = sel;
`ifdef FIFO_ARB_LOCK_EN
          lock_d     = lock[sel];
`endif
        end
      end
      WRITE:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= GW'(NUM_REQ - 1);
      wr_en_q <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
`ifdef FIFO_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wr_en_q <= wr_en_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
`ifdef FIFO_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign ack          = ack_q;
  assign fifo_wr_data = data_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios followed by randomized traffic against a cycle model.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            fifo_full;
`ifdef FIFO_ARB_LOCK_EN
  logic [N-1:0]    lock;
`endif
  logic [N-1:0]    ack;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_data     (req_data),
`ifdef FIFO_ARB_LOCK_EN
    .lock         (lock),
`endif
    .ack          (ack),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  // Reference model: cooldown counts cycles left before the next grant may be sampled.
  bit          m_wr;
  bit [N-1:0]  m_ack;
  bit [DW-1:0] m_data;
  int          m_gid;
  bit          m_busy;
  int          m_last;
  int          m_cool;
  bit          m_lock_on;

  int n_cmp;
  int n_fail;
  bit auto_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_ack = '0; m_data = '0; m_gid = 0; m_busy = 0;
    m_last = N - 1; m_cool = 0; m_lock_on = 0;
  endtask

  task automatic model_edge();
    int w;
    w = -1;
    if (m_cool > 0) begin
      m_cool--;
      m_wr   = 0;
      m_ack  = '0;
      m_busy = (m_cool > 0);
    end else begin
`ifdef FIFO_ARB_LOCK_EN
      if (m_lock_on && lock[m_last] && req[m_last]) w = m_last;
      else m_lock_on = 0;
`endif
      if (w < 0) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (w < 0 && req[i]) w = i;
        end
      end
      if (w >= 0 && !fifo_full) begin
        m_wr   = 1;
        m_ack  = '0;
        m_ack[w] = 1'b1;
        m_data = req_data[w*DW +: DW];
        m_gid  = w;
        m_last = w;
        m_cool = 2;
        m_busy = 1;
`ifdef FIFO_ARB_LOCK_EN
        m_lock_on = lock[w];
`endif
      end else begin
        m_wr   = 0;
        m_ack  = '0;
        m_busy = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("wr_en", fifo_wr_en, m_wr);
    chk("ack", ack, m_ack);
    chk("busy", busy, m_busy);
    if (m_wr) begin
      chk("wr_data", fifo_wr_data, m_data);
      chk("grant_id", grant_id, m_gid);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (auto_drop)
      for (int i = 0; i < N; i++)
        if (m_ack[i]) req[i] = 1'b0;
  endtask

  // Asserts reset immediately, checks the cleared outputs, releases on the next falling edge.
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", fifo_wr_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] oh;
    n_cmp = 0; n_fail = 0; auto_drop = 0;
    req = '0; req_data = '0; fifo_full = 1'b0; reset_n = 1'b1;
`ifdef FIFO_ARB_LOCK_EN
    lock = '0;
`endif
    #2;

    // Single requester straight out of reset.
    req = 4'b0001;
    req_data[31:0] = 32'hDEADBEEF;
    apply_reset();
    step();
    chk("t1_wr", fifo_wr_en, 1);
    chk("t1_data", fifo_wr_data, 32'hDEADBEEF);
    chk("t1_ack", ack, 4'b0001);
    chk("t1_gid", grant_id, 0);
    chk("t1_busy_w", busy, 1);
    req = '0;
    step();
    chk("t1_wr_once", fifo_wr_en, 0);
    chk("t1_busy_s", busy, 1);
    step();
    chk("t1_busy_end", busy, 0);

    // All four requesting, each drops after its ack.
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA0000000 + i;
    req = 4'b1111;
    auto_drop = 1;
    apply_reset();
    for (int g = 0; g < N; g++) begin
      step();
      oh = '0;
      oh[g] = 1'b1;
      chk("t2_gid", grant_id, g);
      chk("t2_ack", ack, oh);
      step();
      step();
    end

    // Full stalls in IDLE; clearing it lets requester 2 through.
    req = 4'b0100;
    fifo_full = 1'b1;
    apply_reset();
    repeat (10) step();
    chk("t3_stall_wr", fifo_wr_en, 0);
    chk("t3_stall_ack", ack, 0);
    fifo_full = 1'b0;
    step();
    chk("t3_wr", fifo_wr_en, 1);
    chk("t3_gid", grant_id, 2);
    step();
    step();

    // Requesters 3 and 1 held continuously alternate; 0 idle.
    auto_drop = 0;
    req = 4'b1000;
    apply_reset();
    step();
    chk("t4_first", grant_id, 3);
    req = 4'b1010;
    step();
    step();
    for (int j = 0; j < 5; j++) begin
      step();
      chk("t4_wr", fifo_wr_en, 1);
      chk("t4_gid", grant_id, (j % 2 == 0) ? 1 : 3);
      chk("t4_no0", ack[0], 0);
      step();
      step();
    end

    // Reset landing in the WRITE cycle.
    req = 4'b0001;
    apply_reset();
    step();
    chk("t5_in_write", fifo_wr_en, 1);
    req = 4'b1011;
    apply_reset();
    step();
    chk("t5_gid", grant_id, 0);
    chk("t5_wr", fifo_wr_en, 1);
    req = '0;
    step();
    step();

`ifdef FIFO_ARB_LOCK_EN
    // Lock burst on requester 2, then release back to round-robin.
    req = 4'b0010;
    lock = '0;
    apply_reset();
    step();
    chk("t6_pre", grant_id, 1);
    req = 4'b0110;
    lock = 4'b0100;
    step();
    step();
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t6_lock_gid", grant_id, 2);
      step();
      step();
    end
    lock = '0;
    step();
    chk("t6_release_gid", grant_id, 1);
    req = '0;
    step();
    step();
`endif

    // Randomized traffic with random full, withdrawals and one mid-run reset.
    auto_drop = 1;
    req = '0;
    fifo_full = 1'b0;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if (c == 400) apply_reset();
      step();
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = $urandom;
        end else if (req[i] && $urandom_range(0, 40) == 0) begin
          req[i] = 1'b0;
        end
      end
      fifo_full = ($urandom_range(0, 4) == 0);
`ifdef FIFO_ARB_LOCK_EN
      lock = N'($urandom);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
